// File: rtl/adapter_ul_pkg.sv
// -----------------------------------------------------------------------------
// adapter_ul_pkg
// Shared definitions for the uplink adapter: IQ/word widths, default slot
// timing, FSM state encoding and the sample-pair packing helper.
// Optional feature macro used by the slice: ADAPTER_UL_COUNTERS_EN.
// -----------------------------------------------------------------------------
package adapter_ul_pkg;

    localparam int IQ_W            = 16;
    localparam int WORD_W          = 32;
    localparam int PAIR_W          = 2 * WORD_W;
    localparam int SLOT_LEN_DEF    = 16;
    localparam int TX_SLOT_DEF     = 13;
    localparam int PRIME_LEVEL_DEF = 4;
    localparam int FIFO_AW_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // s0 is the earlier sample. Result layout is {Q1,Q0,I1,I0}, so the low
    // word is directly the TX I word and the high word the TX Q word.
    function automatic logic [PAIR_W-1:0] pack_pair(input logic [WORD_W-1:0] s0,
                                                    input logic [WORD_W-1:0] s1);
        return {s1[WORD_W-1:IQ_W], s0[WORD_W-1:IQ_W], s1[IQ_W-1:0], s0[IQ_W-1:0]};
    endfunction

endpackage

// File: rtl/adapter_ul_if.sv
// -----------------------------------------------------------------------------
// adapter_ul_if
// Bundles the DDC-side input, the TX-side output, the status flags and the
// debug view (FSM state, FIFO level, pair_half) of the uplink adapter.
//   slave  : used by adapter_ul (inputs tx_enable/ddc_*, drives the rest)
//   master : used by whatever drives the adapter
// With ADAPTER_UL_COUNTERS_EN defined, underrun_cnt/overflow_cnt are added.
//
// Handshake: ddc_data_valid marks one sample on ddc_data_in in that cycle;
// there is no ready, every valid sample is taken (or dropped on overflow).
// iq_tx_data_valid is a one-cycle strobe with iq_tx_i/iq_tx_q valid in the
// same cycle; the consumer has no way to stall it.
// -----------------------------------------------------------------------------
interface adapter_ul_if #(
    parameter int FIFO_ADDR_WIDTH = 4
);
    import adapter_ul_pkg::*;

    logic                     tx_enable;
    logic                     ddc_data_valid;
    logic [WORD_W-1:0]        ddc_data_in;
    logic [WORD_W-1:0]        iq_tx_i;
    logic [WORD_W-1:0]        iq_tx_q;
    logic                     iq_tx_data_valid;
    logic                     underrun;
    logic                     overflow;
    state_t                   state_dbg;
    logic [FIFO_ADDR_WIDTH:0] level_dbg;
    logic                     pair_half_dbg;

`ifdef ADAPTER_UL_COUNTERS_EN
    logic [15:0]              underrun_cnt;
    logic [15:0]              overflow_cnt;

    modport slave (
        input  tx_enable, ddc_data_valid, ddc_data_in,
        output iq_tx_i, iq_tx_q, iq_tx_data_valid, underrun, overflow,
        output state_dbg, level_dbg, pair_half_dbg,
        output underrun_cnt, overflow_cnt
    );
    modport master (
        output tx_enable, ddc_data_valid, ddc_data_in,
        input  iq_tx_i, iq_tx_q, iq_tx_data_valid, underrun, overflow,
        input  state_dbg, level_dbg, pair_half_dbg,
        input  underrun_cnt, overflow_cnt
    );
`else
    modport slave (
        input  tx_enable, ddc_data_valid, ddc_data_in,
        output iq_tx_i, iq_tx_q, iq_tx_data_valid, underrun, overflow,
        output state_dbg, level_dbg, pair_half_dbg
    );
    modport master (
        output tx_enable, ddc_data_valid, ddc_data_in,
        input  iq_tx_i, iq_tx_q, iq_tx_data_valid, underrun, overflow,
        input  state_dbg, level_dbg, pair_half_dbg
    );
`endif

endinterface

// File: rtl/adapter_ul_fifo.sv
// -----------------------------------------------------------------------------
// adapter_ul_fifo
// Synchronous FIFO of sample pairs with simultaneous push/pop and flush.
// Ports:
//   clk_1, rst_n (async, active-low)
//   flush        : empties the FIFO (pointers and level to 0), wins over push/pop
//   push, wdata  : write request; taken if not full, or if a pop happens too
//   pop          : read request; ignored when empty
//   rdata        : head entry (show-ahead, combinational from memory)
//   level, full, empty
// -----------------------------------------------------------------------------
module adapter_ul_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_1,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_1) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/adapter_ul.sv
// -----------------------------------------------------------------------------
// adapter_ul
// Uplink adapter: pairs DDC baseband samples ({Q,I}) and emits one pair per
// TX slot in UTRA-FDD TX word format (iq_tx_i={I1,I0}, iq_tx_q={Q1,Q0}).
// Ports:
//   clk_1  : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : adapter_ul_if.slave (tx_enable, ddc_data_valid/ddc_data_in in;
//            iq_tx_i/iq_tx_q/iq_tx_data_valid, underrun, overflow and the
//            debug state/level/pair_half out)
// Optional: ADAPTER_UL_COUNTERS_EN adds saturating underrun_cnt/overflow_cnt.
// -----------------------------------------------------------------------------
module adapter_ul
    import adapter_ul_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = FIFO_AW_DEF,
    parameter int SLOT_LEN        = SLOT_LEN_DEF,
    parameter int TX_SLOT         = TX_SLOT_DEF,
    parameter int PRIME_LEVEL     = PRIME_LEVEL_DEF
) (
    input  logic        clk_1,
    input  logic        rst_n,
    adapter_ul_if.slave bus
);
    localparam int SC_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(SLOT_LEN - 1);
    localparam logic [SC_W-1:0] SLOT_POP  = SC_W'(TX_SLOT);

    state_t                   state;
    state_t                   state_next;
    logic [SC_W-1:0]          slot_cnt;
    logic                     pair_half;
    logic [WORD_W-1:0]        held_sample;
    logic [WORD_W-1:0]        iq_i_r;
    logic [WORD_W-1:0]        iq_q_r;
    logic                     iq_valid_r;
    logic                     underrun_r;
    logic                     overflow_r;

    logic [PAIR_W-1:0]        fifo_rdata;
    logic [FIFO_ADDR_WIDTH:0] fifo_level;
    logic                     fifo_full;
    logic                     fifo_empty;

    logic                     flush;
    logic                     sample_in;
    logic                     push_req;
    logic                     pop_slot;
    logic                     prime_met;
    logic                     underrun_evt;
    logic                     overflow_evt;

    // Dropping tx_enable flushes everything the same cycle it is seen.
    assign flush        = !bus.tx_enable;
    assign sample_in    = bus.tx_enable && bus.ddc_data_valid;
    assign push_req     = sample_in && pair_half;
    assign pop_slot     = bus.tx_enable && (state == ST_RUN) && (slot_cnt == SLOT_POP);
    assign prime_met    = 32'(fifo_level) >= PRIME_LEVEL;
    assign underrun_evt = pop_slot && fifo_empty;
    // When full, a pop in the same slot always has data to free a place.
    assign overflow_evt = push_req && fifo_full && !pop_slot;

    adapter_ul_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .DATA_WIDTH (PAIR_W)
    ) u_fifo (
        .clk_1 (clk_1),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_req),
        .pop   (pop_slot),
        .wdata (pack_pair(held_sample, bus.ddc_data_in)),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        if (!bus.tx_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_PRIME;
                ST_PRIME: if (prime_met) state_next = ST_RUN;
                ST_RUN:   state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Slot counter runs only in RUN; held at 0 otherwise so the first RUN
    // cycle is slot 0.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (!bus.tx_enable || state != ST_RUN) begin
            slot_cnt <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Pairing: the first sample of a pair waits in held_sample indefinitely.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            pair_half   <= 1'b0;
            held_sample <= '0;
        end else if (!bus.tx_enable) begin
            pair_half   <= 1'b0;
        end else if (bus.ddc_data_valid) begin
            if (!pair_half) held_sample <= bus.ddc_data_in;
            pair_half <= !pair_half;
        end
    end

    // Output registers and sticky flags. An empty pop still strobes with
    // zero data so slot timing never slips.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            iq_i_r     <= '0;
            iq_q_r     <= '0;
            iq_valid_r <= 1'b0;
            underrun_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            iq_valid_r <= pop_slot;
            if (pop_slot) begin
                iq_i_r <= fifo_empty ? '0 : fifo_rdata[WORD_W-1:0];
                iq_q_r <= fifo_empty ? '0 : fifo_rdata[PAIR_W-1:WORD_W];
            end
            if (underrun_evt) underrun_r <= 1'b1;
            if (overflow_evt) overflow_r <= 1'b1;
        end
    end

    assign bus.iq_tx_i          = iq_i_r;
    assign bus.iq_tx_q          = iq_q_r;
    assign bus.iq_tx_data_valid = iq_valid_r;
    assign bus.underrun         = underrun_r;
    assign bus.overflow         = overflow_r;
    assign bus.state_dbg        = state;
    assign bus.level_dbg        = fifo_level;
    assign bus.pair_half_dbg    = pair_half;

`ifdef ADAPTER_UL_COUNTERS_EN
    logic [15:0] underrun_cnt_r;
    logic [15:0] overflow_cnt_r;

    // Event counters saturate; only rst_n clears them.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_r <= '0;
            overflow_cnt_r <= '0;
        end else begin
            if (underrun_evt && underrun_cnt_r != 16'hFFFF)
                underrun_cnt_r <= underrun_cnt_r + 16'd1;
            if (overflow_evt && overflow_cnt_r != 16'hFFFF)
                overflow_cnt_r <= overflow_cnt_r + 16'd1;
        end
    end

    assign bus.underrun_cnt = underrun_cnt_r;
    assign bus.overflow_cnt = overflow_cnt_r;
`endif

endmodule

// File: tb/tb_adapter_ul.sv
// -----------------------------------------------------------------------------
// tb_adapter_ul
// Self-checking bench for adapter_ul: a queue-based reference model is stepped
// every clock and compared to the DUT on every falling edge; directed
// scenarios pin the model with hand-computed values, then randomized traffic
// runs against it. Build with ADAPTER_UL_COUNTERS_EN to also check counters.
// -----------------------------------------------------------------------------
module tb_adapter_ul;
    import adapter_ul_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int SLOT  = 16;
    localparam int TXS   = 13;
    localparam int PRIME = 4;

    logic clk_1;
    logic rst_n;

    adapter_ul_if #(.FIFO_ADDR_WIDTH(AW)) bus ();

    adapter_ul #(
        .FIFO_ADDR_WIDTH (AW),
        .SLOT_LEN        (SLOT),
        .TX_SLOT         (TXS),
        .PRIME_LEVEL     (PRIME)
    ) dut (
        .clk_1 (clk_1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_1 = 1'b0;
        forever #5 clk_1 = ~clk_1;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_fifo[$];
    bit          m_have_half;
    logic [31:0] m_half;
    int          m_mode;        // 0 idle, 1 prime, 2 run
    int          m_run_cycles;
    logic [31:0] m_i, m_q;
    bit          m_valid, m_under, m_over;
    int          m_under_cnt, m_over_cnt;
    int          m_both_full;
    logic [31:0] log_i[$];
    logic [31:0] log_q[$];
    int          log_cyc[$];

    task automatic m_reset();
        m_fifo.delete();
        m_have_half  = 0;
        m_half       = '0;
        m_mode       = 0;
        m_run_cycles = 0;
        m_i = '0; m_q = '0;
        m_valid = 0; m_under = 0; m_over = 0;
        m_under_cnt = 0; m_over_cnt = 0;
    endtask

    task automatic m_step(input bit en, input bit v, input logic [31:0] d);
        int  prior;
        bit  pop;
        logic [63:0] e;
        if (!en) begin
            m_fifo.delete();
            m_have_half  = 0;
            m_mode       = 0;
            m_run_cycles = 0;
            m_valid      = 0;
            return;
        end
        prior = m_fifo.size();
        pop   = (m_mode == 2) && ((m_run_cycles % SLOT) == TXS);
        m_valid = pop;
        if (pop) begin
            if (prior == 0) begin
                m_i = '0; m_q = '0; m_under = 1;
                m_under_cnt = (m_under_cnt < 65535) ? m_under_cnt + 1 : 65535;
            end else begin
                e   = m_fifo.pop_front();
                m_i = e[31:0];
                m_q = e[63:32];
            end
            log_i.push_back(m_i);
            log_q.push_back(m_q);
            log_cyc.push_back(cyc);
        end
        if (v) begin
            if (m_have_half) begin
                m_have_half = 0;
                if (prior < DEPTH || pop) begin
                    if (pop && prior == DEPTH) m_both_full++;
                    m_fifo.push_back({d[31:16], m_half[31:16], d[15:0], m_half[15:0]});
                end else begin
                    m_over = 1;
                    m_over_cnt = (m_over_cnt < 65535) ? m_over_cnt + 1 : 65535;
                end
            end else begin
                m_half      = d;
                m_have_half = 1;
            end
        end
        if (m_mode == 2) m_run_cycles++;
        else if (m_mode == 1) begin
            if (prior >= PRIME) begin m_mode = 2; m_run_cycles = 0; end
        end else m_mode = 1;
    endtask

    function automatic state_t m_state();
        return (m_mode == 2) ? ST_RUN : (m_mode == 1) ? ST_PRIME : ST_IDLE;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    initial begin
        m_reset();
        forever begin
            @(posedge clk_1);
            cyc++;
            if (rst_n === 1'b1) m_step(bus.tx_enable, bus.ddc_data_valid, bus.ddc_data_in);
            @(negedge clk_1);
            if (rst_n !== 1'b1) m_reset();
            chk("iq_tx_i",  64'(bus.iq_tx_i), 64'(m_i));
            chk("iq_tx_q",  64'(bus.iq_tx_q), 64'(m_q));
            chk("valid",    64'(bus.iq_tx_data_valid), 64'(m_valid));
            chk("underrun", 64'(bus.underrun), 64'(m_under));
            chk("overflow", 64'(bus.overflow), 64'(m_over));
            chk("state",    64'(bus.state_dbg), 64'(m_state()));
            chk("level",    64'(bus.level_dbg), 64'(m_fifo.size()));
            chk("pair_half", 64'(bus.pair_half_dbg), 64'(m_have_half));
`ifdef ADAPTER_UL_COUNTERS_EN
            chk("underrun_cnt", 64'(bus.underrun_cnt), 64'(m_under_cnt));
            chk("overflow_cnt", 64'(bus.overflow_cnt), 64'(m_over_cnt));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit en, input bit v, input logic [31:0] d);
        @(posedge clk_1);
        #1;
        bus.tx_enable      = en;
        bus.ddc_data_valid = v;
        bus.ddc_data_in    = d;
    endtask

    task automatic send_seq(input int first, input int count);
        for (int n = first; n < first + count; n++)
            drive(1'b1, 1'b1, {16'(16'h0100 + n), 16'(n)});
        drive(1'b1, 1'b0, '0);
    endtask

    task automatic wait_strobes(input string name, input int target, input int budget);
        int waited = 0;
        while (log_i.size() < target && waited < budget) begin
            @(negedge clk_1);
            waited++;
        end
        chk(name, 64'(log_i.size() >= target), 64'd1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int base;
        bus.tx_enable      = 1'b0;
        bus.ddc_data_valid = 1'b0;
        bus.ddc_data_in    = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk_1);
        chk("rst_iq_tx_i", 64'(bus.iq_tx_i), 64'd0);
        chk("rst_valid",   64'(bus.iq_tx_data_valid), 64'd0);
        chk("rst_flags",   64'({bus.underrun, bus.overflow}), 64'd0);
        chk("rst_state",   64'(bus.state_dbg), 64'(ST_IDLE));
        repeat (2) @(posedge clk_1);
        #1 rst_n = 1'b1;

        // Eight back-to-back samples, then starve: four real pairs, then underruns.
        base = log_i.size();
        send_seq(0, 8);
        wait_strobes("wait_first7", base + 7, 300);
        chk("pin_s0_i", 64'(log_i[base]),   64'h0001_0000);
        chk("pin_s0_q", 64'(log_q[base]),   64'h0101_0100);
        chk("pin_s1_i", 64'(log_i[base+1]), 64'h0003_0002);
        chk("pin_s3_q", 64'(log_q[base+3]), 64'h0107_0106);
        chk("pin_spacing", 64'(log_cyc[base+1] - log_cyc[base]), 64'd16);
        chk("pin_s4_i", 64'(log_i[base+4]), 64'd0);
        chk("pin_s4_q", 64'(log_q[base+4]), 64'd0);
        chk("pin_underrun", 64'(m_under), 64'd1);
`ifdef ADAPTER_UL_COUNTERS_EN
        chk("pin_underrun_cnt", 64'(m_under_cnt), 64'd3);
        chk("dut_underrun_cnt", 64'(bus.underrun_cnt), 64'd3);
`endif

        // Odd sample count then disable: full flush, then clean re-pairing.
        for (int n = 0; n < 3; n++) drive(1'b1, 1'b1, 32'hABCD_0000 + 32'(n));
        drive(1'b0, 1'b0, '0);
        @(posedge clk_1);
        @(negedge clk_1);
        chk("flush_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        chk("flush_level", 64'(bus.level_dbg), 64'd0);
        chk("flush_half",  64'(bus.pair_half_dbg), 64'd0);
        chk("flush_keep_underrun", 64'(bus.underrun), 64'd1);
        base = log_i.size();
        send_seq(16, 8);
        wait_strobes("wait_repair", base + 1, 100);
        chk("pin_repair_i", 64'(log_i[base]), 64'h0011_0010);
        chk("pin_repair_q", 64'(log_q[base]), 64'h0111_0110);

        // Flood: overflow, plus gaps to hit push+pop on a full FIFO.
        drive(1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 48; n++) drive(1'b1, 1'b1, $urandom);
            drive(1'b1, 1'b0, '0);
        end
        @(negedge clk_1);
        chk("pin_overflow", 64'(m_over), 64'd1);
        chk("dut_overflow", 64'(bus.overflow), 64'd1);
        chk("pin_full_pushpop", 64'(m_both_full > 0), 64'd1);

        // Randomized traffic at several sample rates with rare disables.
        for (int blk = 0; blk < 8; blk++) begin
            int rate;
            rate = (blk % 4 == 0) ? 10 : (blk % 4 == 1) ? 13 : (blk % 4 == 2) ? 30 : 90;
            for (int c = 0; c < 500; c++)
                drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < rate), $urandom);
        end

        // Asynchronous reset in the middle of a slot.
        send_seq(32, 8);
        repeat (20) @(posedge clk_1);
        #3 rst_n = 1'b0;
        @(negedge clk_1);
        chk("areset_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        chk("areset_flags", 64'({bus.underrun, bus.overflow}), 64'd0);
        chk("areset_iq",    64'({bus.iq_tx_i, bus.iq_tx_q}), 64'd0);
        chk("areset_level", 64'(bus.level_dbg), 64'd0);
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk_1);
        @(negedge clk_1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
